// File: rtl/change_event_sequencer_if.sv
// Script-entry write handshake between a host (master) and change_event_sequencer (slave).
interface change_event_sequencer_if #(
    parameter int W     = 2,
    parameter int DLY_W = 8
) ();
    logic             wr_valid;
    logic             wr_ready;
    logic [W-1:0]     wr_a;
    logic [W-1:0]     wr_b;
    logic [DLY_W-1:0] wr_dly;

    modport master (output wr_valid, output wr_a, output wr_b, output wr_dly, input wr_ready);
    modport slave  (input wr_valid, input wr_a, input wr_b, input wr_dly, output wr_ready);
endinterface

// File: rtl/change_event_sequencer.sv
// Plays a host-loaded (a, b, delay) script onto two registered buses and flags per-bus changes.
// Define SEQ_TIMESTAMP_EN to stamp each event with a free-running 16-bit cycle count.
module change_event_sequencer #(
    parameter int W     = 2,
    parameter int DLY_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    change_event_sequencer_if.slave wr,
    input  logic                    start_i,
    output logic [W-1:0]            a_out_o,
    output logic [W-1:0]            b_out_o,
    output logic                    ev_valid_o,
    output logic [1:0]              ev_mask_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [7:0]              nochg_cnt_o,
    output logic [15:0]             ev_time_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_APPLY
    } state_e;

    typedef struct packed {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [DLY_W-1:0] dly;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             full, empty, push, pop;
    entry_t           head;

    logic [W-1:0]     cur_a_q, cur_a_d;
    logic [W-1:0]     cur_b_q, cur_b_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             ev_valid_q, ev_valid_d;
    logic [1:0]       ev_mask_q, ev_mask_d;
    logic             done_q, done_d;
    logic [7:0]       nochg_q, nochg_d;
    logic             first_q, first_d;
    logic [15:0]      ev_time_q, ev_time_d;
    logic [1:0]       mask;
    logic [15:0]      stamp;

    // Occupancy is the registered pointer difference, so a pop in this cycle frees space only next cycle.
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push        = wr.wr_valid && !full;
    assign pop         = (state_q == S_LOAD);
    assign wr.wr_ready = !full;
    assign head        = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone define which slots hold valid entries.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {wr.wr_a, wr.wr_b, wr.wr_dly};
    end

`ifdef SEQ_TIMESTAMP_EN
    logic [15:0] ts_q;

    always_ff @(posedge clk) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + 16'd1;
    end

    assign stamp = ts_q;
`else
    assign stamp = '0;
`endif

    // The first applied entry after reset leaves an undefined bus state, so both buses count as changed.
    assign mask = first_q ? 2'b11 : {cur_b_q != b_q, cur_a_q != a_q};

    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    always_comb begin
        state_d    = state_q;
        cur_a_d    = cur_a_q;
        cur_b_d    = cur_b_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        ev_valid_d = 1'b0;
        ev_mask_d  = 2'b00;
        done_d     = 1'b0;
        nochg_d    = nochg_q;
        first_d    = first_q;
        ev_time_d  = ev_time_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                cur_a_d = head.a;
                cur_b_d = head.b;
                cnt_d   = head.dly;
                state_d = (head.dly == '0) ? S_APPLY : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - DLY_W'(1);
                if (cnt_q == DLY_W'(1)) state_d = S_APPLY;
            end
            S_APPLY: begin
                a_d        = cur_a_q;
                b_d        = cur_b_q;
                first_d    = 1'b0;
                ev_valid_d = (mask != 2'b00);
                ev_mask_d  = mask;
                if (mask == 2'b00) begin
                    if (nochg_q != 8'hFF) nochg_d = nochg_q + 8'd1;
                end else begin
                    ev_time_d = stamp;
                end
                // An entry pushed during this cycle is not yet visible in the registered empty flag.
                if (empty) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_a_q    <= '0;
            cur_b_q    <= '0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ev_valid_q <= 1'b0;
            ev_mask_q  <= 2'b00;
            done_q     <= 1'b0;
            nochg_q    <= '0;
            first_q    <= 1'b1;
            ev_time_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_a_q    <= cur_a_d;
            cur_b_q    <= cur_b_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ev_valid_q <= ev_valid_d;
            ev_mask_q  <= ev_mask_d;
            done_q     <= done_d;
            nochg_q    <= nochg_d;
            first_q    <= first_d;
            ev_time_q  <= ev_time_d;
        end
    end

    assign a_out_o     = a_q;
    assign b_out_o     = b_q;
    assign ev_valid_o  = ev_valid_q;
    assign ev_mask_o   = ev_mask_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign nochg_cnt_o = nochg_q;
    assign ev_time_o   = ev_time_q;

endmodule

// File: tb/tb_change_event_sequencer.sv
// Self-checking bench: a schedule model predicts every output per cycle from the script timing rules.
module tb_change_event_sequencer;
    localparam int W     = 2;
    localparam int DLY_W = 8;
    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  a_out, b_out, ev_mask;
    logic        ev_valid, busy, done;
    logic [7:0]  nochg_cnt;
    logic [15:0] ev_time;

    change_event_sequencer_if #(.W(W), .DLY_W(DLY_W)) wr_if ();

    change_event_sequencer #(.W(W), .DLY_W(DLY_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr_if),
        .start_i     (start),
        .a_out_o     (a_out),
        .b_out_o     (b_out),
        .ev_valid_o  (ev_valid),
        .ev_mask_o   (ev_mask),
        .busy_o      (busy),
        .done_o      (done),
        .nochg_cnt_o (nochg_cnt),
        .ev_time_o   (ev_time)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [7:0] d;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [1:0]  a;
        logic [1:0]  b;
        logic        ev;
        logic [1:0]  mask;
        logic        done;
        logic [7:0]  nochg;
        logic [15:0] evt;
    } step_t;

    // Planning state: what the script implies once every scheduled entry has been applied.
    ent_t        m_fifo[$];
    step_t       sched[$];
    int          loads[$];
    logic [1:0]  m_a, m_b;
    logic        m_first;
    logic [7:0]  m_nochg;
    logic [15:0] m_evt;
    int          busy_from, busy_to;
`ifdef SEQ_TIMESTAMP_EN
    int          rst_cyc;
`endif

    // Expected visible values, advanced by the compare process as schedule steps come due.
    logic [1:0]  e_a, e_b, e_mask;
    logic        e_ev, e_done;
    logic [7:0]  e_nochg;
    logic [15:0] e_evt;
    step_t       cur;
    bit          chk_en = 1'b0;

    logic [1:0]  obs_mask[$];
    int          obs_ev_cyc[$];
    logic [15:0] obs_evt[$];
    int          obs_done;

    function automatic int occ(input int t);
        int n;
        n = m_fifo.size();
        foreach (loads[i]) if (loads[i] >= t) n++;
        return n;
    endfunction

    // Entry loaded in cycle 'load' becomes visible at load+dly+2; the next entry loads that same cycle.
    task automatic plan_entry(input ent_t e, input int load, input bit chain);
        step_t s;
        logic [1:0] mask;
        mask = m_first ? 2'b11 : {e.b != m_b, e.a != m_a};
        m_first = 1'b0;
        if (mask == 2'b00) begin
            if (m_nochg != 8'hFF) m_nochg = m_nochg + 8'd1;
        end else begin
`ifdef SEQ_TIMESTAMP_EN
            m_evt = 16'(load + int'(e.d) + 1 - rst_cyc);
`endif
        end
        m_a = e.a;
        m_b = e.b;
        if (chain && sched.size() > 0) sched[sched.size()-1].done = 1'b0;
        s.cyc   = load + int'(e.d) + 2;
        s.a     = e.a;
        s.b     = e.b;
        s.ev    = (mask != 2'b00);
        s.mask  = mask;
        s.done  = 1'b1;
        s.nochg = m_nochg;
        s.evt   = m_evt;
        sched.push_back(s);
        loads.push_back(load);
        busy_to = s.cyc;
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef SEQ_TIMESTAMP_EN
        rst_cyc = cyc;
`endif
        m_fifo.delete();
        sched.delete();
        loads.delete();
        m_a = 0; m_b = 0; m_first = 1'b1; m_nochg = 0; m_evt = 0;
        e_a = 0; e_b = 0; e_nochg = 0; e_evt = 0;
        busy_from = 0;
        busy_to   = 0;
        chk_en    = 1'b1;
    endtask

    task automatic push(input logic [1:0] a, input logic [1:0] b, input logic [7:0] d, output bit acc);
        ent_t e;
        int t;
        t   = cyc;
        e   = '{a, b, d};
        acc = (occ(t) < DEPTH);
        check("wr_ready", wr_if.wr_ready, acc);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_a     = a;
        wr_if.wr_b     = b;
        wr_if.wr_dly   = d;
        if (acc) begin
            // Seen by the running playback only if it lands before the last entry's empty check.
            if (t >= busy_from && t < busy_to - 1) plan_entry(e, busy_to, 1'b1);
            else m_fifo.push_back(e);
        end
        @(posedge clk);
        #1;
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic push_retry(input logic [1:0] a, input logic [1:0] b, input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) push(a, b, d, acc);
    endtask

    task automatic do_start();
        int t;
        int load;
        bit chain;
        t     = cyc;
        start = 1'b1;
        if (!(t >= busy_from && t < busy_to) && m_fifo.size() > 0) begin
            load      = t + 1;
            busy_from = load;
            chain     = 1'b0;
            while (m_fifo.size() > 0) begin
                plan_entry(m_fifo.pop_front(), load, chain);
                load  = busy_to;
                chain = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int lim;
        lim = cyc + 3000;
        while ((sched.size() > 0 || cyc < busy_to) && cyc < lim) begin
            @(posedge clk);
            #1;
        end
        check("playback_drained", sched.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        obs_mask.delete();
        obs_ev_cyc.delete();
        obs_evt.delete();
        obs_done = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            e_ev   = 1'b0;
            e_mask = 2'b00;
            e_done = 1'b0;
            if (sched.size() > 0 && sched[0].cyc < cyc) begin
                check("sched_missed", sched[0].cyc, cyc);
                void'(sched.pop_front());
            end
            if (sched.size() > 0 && sched[0].cyc == cyc) begin
                cur     = sched.pop_front();
                e_a     = cur.a;
                e_b     = cur.b;
                e_ev    = cur.ev;
                e_mask  = cur.ev ? cur.mask : 2'b00;
                e_done  = cur.done;
                e_nochg = cur.nochg;
                e_evt   = cur.evt;
            end
            check("a_out", a_out, e_a);
            check("b_out", b_out, e_b);
            check("ev_valid", ev_valid, e_ev);
            check("ev_mask", ev_mask, e_mask);
            check("done", done, e_done);
            check("nochg_cnt", nochg_cnt, e_nochg);
            check("ev_time", ev_time, e_evt);
            check("busy", busy, (cyc >= busy_from && cyc < busy_to));
            if (ev_valid) begin
                obs_mask.push_back(ev_mask);
                obs_ev_cyc.push_back(cyc);
                obs_evt.push_back(ev_time);
            end
            if (done) obs_done++;
        end
    end

    initial begin
        bit acc;
        int t0;
        int n;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_a     = '0;
        wr_if.wr_b     = '0;
        wr_if.wr_dly   = '0;
        clear_obs();
        reset_dut();

        check("rst_a_out", a_out, 0);
        check("rst_b_out", b_out, 0);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_nochg", nochg_cnt, 0);
        check("rst_wr_ready", wr_if.wr_ready, 1);

        // Five-entry script; the fifth goes in once the first pop frees a slot.
        clear_obs();
        push(2'd0, 2'd0, 8'd0, acc);
        push(2'd0, 2'd1, 8'd10, acc);
        push(2'd1, 2'd1, 8'd10, acc);
        push(2'd1, 2'd1, 8'd20, acc);
        do_start();
        push_retry(2'd2, 2'd3, 8'd30);
        do_start();
        wait_idle();
        check("a_mask_count", obs_mask.size(), 4);
        if (obs_mask.size() == 4) begin
            check("a_mask0", obs_mask[0], 2'b11);
            check("a_mask1", obs_mask[1], 2'b10);
            check("a_mask2", obs_mask[2], 2'b01);
            check("a_mask3", obs_mask[3], 2'b11);
        end
        check("a_nochg", nochg_cnt, 1);
        check("a_done_count", obs_done, 1);
        check("a_final_a", a_out, 2);
        check("a_final_b", b_out, 3);

        // Zero-delay entry: visible three cycles after the start cycle.
        clear_obs();
        push(2'd3, 2'd2, 8'd0, acc);
        t0 = cyc;
        do_start();
        wait_idle();
        check("b_ev_count", obs_ev_cyc.size(), 1);
        if (obs_ev_cyc.size() == 1) check("b_ev_latency", obs_ev_cyc[0] - t0, 3);
        check("b_a_out", a_out, 3);
        check("b_b_out", b_out, 2);

        // Full FIFO back-pressure; an extra offer is dropped.
        clear_obs();
        push(2'd0, 2'd0, 8'd1, acc);
        push(2'd1, 2'd0, 8'd1, acc);
        push(2'd2, 2'd0, 8'd1, acc);
        push(2'd3, 2'd0, 8'd1, acc);
        check("c_full_ready", wr_if.wr_ready, 0);
        push(2'd1, 2'd1, 8'd1, acc);
        do_start();
        check("c_ready_load_cycle", wr_if.wr_ready, 0);
        @(posedge clk);
        #1;
        check("c_ready_after_pop", wr_if.wr_ready, 1);
        wait_idle();
        check("c_final_a", a_out, 3);
        check("c_final_b", b_out, 0);
        check("c_ev_count", obs_mask.size(), 4);

        // Mid-run reset during the wait of entry 2 of 4.
        reset_dut();
        push(2'd1, 2'd2, 8'd3, acc);
        push(2'd2, 2'd1, 8'd8, acc);
        push(2'd3, 2'd3, 8'd2, acc);
        push(2'd0, 2'd1, 8'd1, acc);
        t0 = cyc;
        do_start();
        while (cyc < t0 + 9) begin
            @(posedge clk);
            #1;
        end
        check("d_pre_rst_a", a_out, 1);
        reset_dut();
        check("d_rst_a_out", a_out, 0);
        check("d_rst_b_out", b_out, 0);
        check("d_rst_busy", busy, 0);
        check("d_rst_wr_ready", wr_if.wr_ready, 1);
        clear_obs();
        do_start();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("d_empty_start_busy", busy, 0);
        check("d_empty_start_done", obs_done, 0);
        push(2'd0, 2'd0, 8'd0, acc);
        do_start();
        wait_idle();
        check("d_first_count", obs_mask.size(), 1);
        if (obs_mask.size() == 1) check("d_first_mask", obs_mask[0], 2'b11);

        // Event stamps two entries apart.
        reset_dut();
        clear_obs();
        push(2'd1, 2'd0, 8'd5, acc);
        push(2'd2, 2'd0, 8'd5, acc);
        do_start();
        wait_idle();
        check("e_ev_count", obs_evt.size(), 2);
        if (obs_evt.size() == 2) begin
`ifdef SEQ_TIMESTAMP_EN
            check("e_stamp_delta", 32'(obs_evt[1] - obs_evt[0]), 7);
`else
            check("e_stamp0", obs_evt[0], 0);
            check("e_stamp1", obs_evt[1], 0);
`endif
            check("e_ev_spacing", obs_ev_cyc[1] - obs_ev_cyc[0], 7);
        end

        // No-change counter saturation, streamed while playback runs.
        reset_dut();
        clear_obs();
        push(2'd1, 2'd1, 8'd0, acc);
        do_start();
        n = 0;
        for (int k = 0; k < 2000 && n < 300; k++) begin
            push(2'd1, 2'd1, 8'd0, acc);
            if (acc) n++;
        end
        wait_idle();
        check("f_nochg_sat", nochg_cnt, 255);
        check("f_ev_count", obs_mask.size(), 1);
        check("f_done_count", obs_done, 1);
        check("f_a_out", a_out, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
